// File: rtl/addsub_pkg.sv
// Shared types and constants for the bit-serial add/subtract unit.
//   state_t : FSM state encoding (IDLE, RUN, DONE)
//   OP_ADD  : opcode for a + b + cin
//   OP_SUB  : opcode for a + ~b + cin
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage : addsub_pkg

// File: rtl/full_adder_cell.sv
// One-bit full adder. This is the only arithmetic cell in the serial unit.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule : full_adder_cell

// File: rtl/serial_addsub_unit.sv
// Bit-serial, handshaked 8-bit (WIDTH) adder/subtractor. It accepts one request,
// processes one bit per clock (LSB first) through a single full-adder cell, and
// holds {carry, sum} until the consumer takes it.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : request handshake (a, b, cin, opcode sampled on accept)
//   out_valid/ out_ready: result handshake (sum, carry held while out_valid)
//   busy                : unit is not idle
module serial_addsub_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, b_sh_q, sum_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               fa_s, fa_co;
  logic               accept;
  logic               last_bit;

  assign accept   = (state_q == IDLE) && in_valid;
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  full_adder_cell u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // NOTE: sequential state uses non-blocking (<=) so every register samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the datapath registers are plain flops (not a memory array), so they
  // are all reset; an abort mid-transaction therefore leaves sum/carry at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_sh_q  <= a;
      // Subtraction is folded into the operand: a + ~b + cin.
      b_sh_q  <= (opcode == OP_SUB) ? ~b : b;
      carry_q <= cin;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      // Result bits enter at the MSB; after WIDTH shifts bit 0 lands at sum[0].
      sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
      a_sh_q  <= a_sh_q >> 1;
      b_sh_q  <= b_sh_q >> 1;
      carry_q <= fa_co;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign carry     = carry_q;

endmodule : serial_addsub_unit

// File: tb/tb_serial_addsub_unit.sv
// Self-checking bench for serial_addsub_unit: directed vector table, backpressure
// and mid-RUN reset sequences, then randomized requests against an arithmetic model.
module tb_serial_addsub_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin, opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  serial_addsub_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         op;
    logic [W-1:0] exp_sum;
    logic         exp_carry;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain (W+1)-bit arithmetic from the add/subtract rules.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci, input logic op);
    int unsigned yy;
    int unsigned r;
    yy = op ? ((1 << W) - 1 - int'(y)) : int'(y);
    r  = int'(x) + yy + int'(ci);
    return r[W:0];
  endfunction

  // Called at posedge+1; waits (bounded) for in_ready, then performs one accept.
  task automatic send_req(input logic [W-1:0] ra, input logic [W-1:0] rb,
                          input logic rcin, input logic rop);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = ra; b = rb; cin = rcin; opcode = rop;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs: they must not affect the transaction in flight.
    a = W'($urandom); b = W'($urandom);
    cin = 1'($urandom); opcode = 1'($urandom);
  endtask

  // Counts edges from accept until out_valid is seen (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!out_valid && lat <= W) begin
        check("busy_in_run", 32'(busy), 32'd1);
        check("in_ready_in_run", 32'(in_ready), 32'd0);
      end
    end while (!out_valid && lat < 40);
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  vec_t vecs[6];
  int   lat;
  logic [W:0] exp_r;
  bit   seen_valid;

  initial begin
    in_valid = 0; a = '0; b = '0; cin = 0; opcode = 0; out_ready = 0;
    rst_n = 1'b0;
    #12;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_carry",     32'(carry),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors (expected values from hand arithmetic).
    vecs[0] = '{8'd100, 8'd100, 1'b0, 1'b0, 8'd200, 1'b0};
    vecs[1] = '{8'd200, 8'd200, 1'b0, 1'b0, 8'd144, 1'b1};
    vecs[2] = '{8'd10,  8'd10,  1'b1, 1'b1, 8'd0,   1'b1};
    vecs[3] = '{8'd1,   8'd2,   1'b1, 1'b1, 8'd255, 1'b0};
    vecs[4] = '{8'd15,  8'd31,  1'b1, 1'b1, 8'd240, 1'b0};
    vecs[5] = '{8'd255, 8'd0,   1'b1, 1'b0, 8'd0,   1'b1};

    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_req(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op);
      wait_result(lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(W));
      check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].exp_sum));
      check($sformatf("vec%0d_carry", i), 32'(carry), 32'(vecs[i].exp_carry));
      check($sformatf("vec%0d_excl", i), 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_consumed", i), 32'(out_valid), 32'd0);
      check($sformatf("vec%0d_ready_back", i), 32'(in_ready), 32'd1);
    end

    // Backpressure then back-to-back.
    out_ready = 1'b0;
    send_req(8'd9, 8'd6, 1'b1, 1'b1);
    wait_result(lat);
    check("bp_sum", 32'(sum), 32'd3);
    check("bp_carry", 32'(carry), 32'd1);
    in_valid = 1'b1;  // must be ignored while in DONE
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_hold_sum", 32'(sum), 32'd3);
      check("bp_hold_carry", 32'(carry), 32'd1);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    send_req(8'd50, 8'd60, 1'b0, 1'b0);
    wait_result(lat);
    check("b2b_latency", 32'(lat), 32'(W));
    check("b2b_sum", 32'(sum), 32'd110);
    check("b2b_carry", 32'(carry), 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of RUN.
    out_ready = 1'b1;
    send_req(8'd20, 8'd100, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready",  32'(in_ready),  32'd1);
    check("abort_busy",      32'(busy),      32'd0);
    check("abort_sum",       32'(sum),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    check("abort_no_result", 32'(seen_valid), 32'd0);
    send_req(8'd20, 8'd0, 1'b1, 1'b1);
    wait_result(lat);
    check("post_abort_sum", 32'(sum), 32'd20);
    check("post_abort_carry", 32'(carry), 32'd1);
    @(posedge clk); #1;

    // Randomized requests with random consumer stall.
    for (int t = 0; t < 40; t++) begin
      logic [W-1:0] ra, rb;
      logic         rc, ro;
      int           stall;
      ra = W'($urandom); rb = W'($urandom);
      rc = 1'($urandom); ro = 1'($urandom);
      stall = $urandom_range(0, 3);
      exp_r = model(ra, rb, rc, ro);
      out_ready = 1'b0;
      send_req(ra, rb, rc, ro);
      wait_result(lat);
      check($sformatf("rnd%0d_latency", t), 32'(lat), 32'(W));
      check($sformatf("rnd%0d_sum", t), 32'(sum), 32'(exp_r[W-1:0]));
      check($sformatf("rnd%0d_carry", t), 32'(carry), 32'(exp_r[W]));
      repeat (stall) begin
        @(posedge clk); #1;
        check($sformatf("rnd%0d_hold", t), 32'({carry, sum}), 32'(exp_r));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check($sformatf("rnd%0d_ready_back", t), 32'(in_ready), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_serial_addsub_unit
